// File: rtl/dogx_cic_decimator_if.sv
// Sample-stream bundle between the converter front end and the CIC decimator.
// The master drives samples in; the slave returns decimated PCM and the block phase.
interface dogx_cic_decimator_if #(
  parameter int unsigned IN_W  = 11,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned DECIM = 64
);
  localparam int unsigned PH_W = $clog2(DECIM);

  logic signed [IN_W-1:0]  data_in;
  logic                    data_in_valid;
  logic signed [OUT_W-1:0] data_out;
  logic                    data_out_valid;
  logic [PH_W-1:0]         block_phase;

  modport master (
    output data_in,
    output data_in_valid,
    input  data_out,
    input  data_out_valid,
    input  block_phase
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_out,
    output data_out_valid,
    output block_phase
  );
endinterface

// File: rtl/dogx_cic_decimator.sv
// Third-order CIC decimator (M=1) with round-half-up rescale to OUT_W.
// Optional DC blocker after the scaler when DOGX_CIC_DCBLOCK_EN is defined.
module dogx_cic_decimator #(
  parameter int unsigned IN_W      = 11,
  parameter int unsigned DECIM     = 64,
  parameter int unsigned OUT_W     = 16,
  parameter int unsigned DCB_SHIFT = 10
) (
  input logic                  CLK_3M,
  input logic                  reset,
  dogx_cic_decimator_if.slave  bus
);
  localparam int unsigned PH_W  = $clog2(DECIM);
  localparam int unsigned ACC_W = IN_W + 3 * PH_W;
  localparam int unsigned SH    = ACC_W - OUT_W;
  localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (SH - 1);

  logic                    accept;
  logic                    phase_last;
  logic [PH_W-1:0]         phase_q;
  logic                    tick_q;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] int1_q, int2_q, int3_q;
  logic signed [ACC_W-1:0] int1_d, int2_d, int3_d;
  logic signed [ACC_W-1:0] d1_q, d2_q, d3_q;
  logic signed [ACC_W-1:0] c0, c1, c2, c3;
  logic signed [ACC_W:0]   rnd_sum;
  logic signed [OUT_W:0]   rnd;
  logic signed [OUT_W-1:0] scaled;
  logic signed [OUT_W-1:0] out_q;
  logic                    out_valid_q;

  assign accept     = bus.data_in_valid;
  assign phase_last = (phase_q == PH_W'(DECIM - 1));
  assign x_ext      = {{(ACC_W - IN_W){bus.data_in[IN_W-1]}}, bus.data_in};

  // Integrators wrap modulo 2^ACC_W on purpose; the combs cancel the wrap exactly.
  always_comb begin
    int1_d = int1_q + x_ext;
    int2_d = int2_q + int1_d;
    int3_d = int3_q + int2_d;
  end

  always_comb begin
    c0 = int3_q;
    c1 = c0 - d1_q;
    c2 = c1 - d2_q;
    c3 = c2 - d3_q;
  end

  // Only the positive edge can overflow after adding the half LSB.
  always_comb begin
    rnd_sum = {c3[ACC_W-1], c3} + HALF;
    rnd     = rnd_sum[ACC_W:SH];
    scaled  = rnd[OUT_W-1:0];
    if (rnd[OUT_W] != rnd[OUT_W-1]) begin
      scaled = {1'b0, {(OUT_W - 1){1'b1}}};
    end
  end

  always_ff @(posedge CLK_3M or negedge reset) begin
    if (!reset) begin
      int1_q  <= '0;
      int2_q  <= '0;
      int3_q  <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      phase_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      if (accept) begin
        int1_q  <= int1_d;
        int2_q  <= int2_d;
        int3_q  <= int3_d;
        phase_q <= phase_q + PH_W'(1);
      end
      tick_q <= accept & phase_last;
      if (tick_q) begin
        d1_q <= c0;
        d2_q <= c1;
        d3_q <= c2;
      end
    end
  end

`ifdef DOGX_CIC_DCBLOCK_EN
  localparam int unsigned YW = OUT_W + DCB_SHIFT + 2;

  logic signed [OUT_W-1:0] sc_q, xp_q;
  logic                    sc_vld_q;
  logic signed [OUT_W:0]   dx;
  logic signed [YW-1:0]    dx_ext, yf_q, yf_sum, yf_sat;
  logic                    unused_bits;

  // y_prev is kept with DCB_SHIFT fraction bits so the leak term does not truncate to zero.
  always_comb begin
    dx     = {sc_q[OUT_W-1], sc_q} - {xp_q[OUT_W-1], xp_q};
    dx_ext = {{(YW - OUT_W - 1){dx[OUT_W]}}, dx};
    yf_sum = (dx_ext <<< DCB_SHIFT) + yf_q - (yf_q >>> DCB_SHIFT);
    yf_sat = yf_sum;
    if (!((yf_sum[YW-1:OUT_W+DCB_SHIFT-1] == 3'b000) ||
          (yf_sum[YW-1:OUT_W+DCB_SHIFT-1] == 3'b111))) begin
      yf_sat = yf_sum[YW-1] ? {3'b111, {(OUT_W + DCB_SHIFT - 1){1'b0}}}
                            : {3'b000, {(OUT_W + DCB_SHIFT - 1){1'b1}}};
    end
  end

  always_ff @(posedge CLK_3M or negedge reset) begin
    if (!reset) begin
      sc_q        <= '0;
      sc_vld_q    <= 1'b0;
      xp_q        <= '0;
      yf_q        <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sc_vld_q    <= tick_q;
      out_valid_q <= sc_vld_q;
      if (tick_q) begin
        sc_q <= scaled;
      end
      if (sc_vld_q) begin
        xp_q  <= sc_q;
        yf_q  <= yf_sat;
        out_q <= yf_sat[OUT_W+DCB_SHIFT-1:DCB_SHIFT];
      end
    end
  end

  assign unused_bits = ^{rnd_sum[SH-1:0], yf_sat[DCB_SHIFT-1:0],
                         yf_sat[YW-1:OUT_W+DCB_SHIFT]};
`else
  logic unused_bits;

  always_ff @(posedge CLK_3M or negedge reset) begin
    if (!reset) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= tick_q;
      if (tick_q) begin
        out_q <= scaled;
      end
    end
  end

  assign unused_bits = ^{rnd_sum[SH-1:0], 32'(DCB_SHIFT)};
`endif

  assign bus.data_out       = out_q;
  assign bus.data_out_valid = out_valid_q;
  assign bus.block_phase    = phase_q;
endmodule

// File: tb/tb_dogx_cic_decimator.sv
// Bench for dogx_cic_decimator: CIC kernel convolution model feeding a timed scoreboard,
// a vector table of constant-input runs, and hand sequences for reset/step/random cases.
module tb_dogx_cic_decimator;
  localparam int R    = 64;
  localparam int KLEN = 3 * R - 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dogx_cic_decimator_if #(.IN_W(11), .OUT_W(16), .DECIM(R)) bus ();

  dogx_cic_decimator dut (
    .CLK_3M (clk),
    .reset  (rst_n),
    .bus    (bus.slave)
  );

  typedef struct {
    int val;
    int due;
  } exp_t;

  typedef struct {
    int x;
    bit toggle;
    int nblk;
    int first;
    int steady;
  } vec_t;

  exp_t exp_q[$];
  int   hist[$];
  int   h[KLEN];
  int   checks = 0;
  int   failures = 0;
  int   ncyc = 0;
  int   m_phase = 0;
  int   last_out = 0;
  int   first_out = 99999;
  bit   got_first = 1'b0;

  // CIC impulse response: boxcar of length R convolved with itself three times.
  initial begin
    int t2[2*R-1];
    for (int i = 0; i < 2 * R - 1; i++) t2[i] = 0;
    for (int i = 0; i < KLEN; i++) h[i] = 0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < R; j++) t2[i+j] += 1;
    for (int i = 0; i < 2 * R - 1; i++)
      for (int j = 0; j < R; j++) h[i+j] += t2[i];
  end

  function automatic int model_out();
    longint acc = 0;
    int sz = hist.size();
    for (int n = 0; n < sz; n++) acc += longint'(h[n]) * longint'(hist[sz-1-n]);
    acc = (acc + 4096) >>> 13;
    if (acc > 32767) acc = 32767;
    return int'(acc);
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Inputs seen at a falling edge are the ones accepted at the following rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hist.delete();
      m_phase   = 0;
      last_out  = 0;
      got_first = 1'b0;
      first_out = 99999;
    end else begin
      if (bus.data_out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("strobe_time", ncyc, e.due);
          check("data_out", int'(bus.data_out), e.val);
        end
        last_out = int'(bus.data_out);
        if (!got_first) begin
          first_out = last_out;
          got_first = 1'b1;
        end
      end else begin
        if (exp_q.size() > 0 && exp_q[0].due < ncyc) begin
          check("missed_strobe", 0, 1);
          void'(exp_q.pop_front());
        end
        check("hold", int'(bus.data_out), last_out);
      end
      check("block_phase", int'(bus.block_phase), m_phase);
      if (bus.data_in_valid) begin
        hist.push_back(int'(bus.data_in));
        if (hist.size() > KLEN) void'(hist.pop_front());
        if (m_phase == R - 1) exp_q.push_back('{val: model_out(), due: ncyc + 2});
        m_phase = (m_phase + 1) % R;
      end
    end
    ncyc++;
  end

  task automatic drive(input bit v, input int x);
    bus.data_in_valid = v;
    bus.data_in       = 11'(x);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.data_in_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    repeat (4) drive(1'b0, 0);
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{x: 100,   toggle: 1'b0, nblk: 6,  first: 559,   steady: 3200};
    tbl[1] = '{x: -1024, toggle: 1'b0, nblk: 20, first: -5720, steady: -32768};
    tbl[2] = '{x: 1023,  toggle: 1'b0, nblk: 20, first: 5714,  steady: 32736};
    tbl[3] = '{x: 100,   toggle: 1'b1, nblk: 6,  first: 559,   steady: 3200};
    tbl[4] = '{x: -100,  toggle: 1'b0, nblk: 6,  first: -559,  steady: -3200};
    tbl[5] = '{x: 0,     toggle: 1'b0, nblk: 3,  first: 0,     steady: 0};
    tbl[6] = '{x: -1,    toggle: 1'b0, nblk: 5,  first: -6,    steady: -32};
    tbl[7] = '{x: 512,   toggle: 1'b0, nblk: 6,  first: 2860,  steady: 16384};

    bus.data_in       = '0;
    bus.data_in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("reset_data_out", int'(bus.data_out), 0);
    check("reset_valid", int'(bus.data_out_valid), 0);
    check("reset_phase", int'(bus.block_phase), 0);

    for (int r = 0; r < 8; r++) begin
      int ncy;
      do_reset();
      ncy = tbl[r].nblk * R * (tbl[r].toggle ? 2 : 1);
      for (int i = 0; i < ncy; i++) drive(tbl[r].toggle ? (i % 2 == 0) : 1'b1, tbl[r].x);
      drain();
      check($sformatf("vec%0d_first", r), first_out, tbl[r].first);
      check($sformatf("vec%0d_steady", r), last_out, tbl[r].steady);
    end

    // Step 0 -> +100 on the sample right after the completing one.
    do_reset();
    for (int i = 0; i < R; i++) drive(1'b1, 0);
    for (int i = 0; i < 5 * R; i++) drive(1'b1, 100);
    drain();
    check("step_steady", last_out, 3200);

    // Mid-block reset: asynchronous clear, partial block discarded.
    do_reset();
    for (int i = 0; i < 2 * R; i++) drive(1'b1, 100);
    for (int i = 0; i < 2 * R && int'(bus.block_phase) != 30; i++) drive(1'b1, 100);
    check("phase_at_30", int'(bus.block_phase), 30);
    check("out_before_reset_nonzero", int'(bus.data_out != 0), 1);
    rst_n = 1'b0;
    #1;
    check("async_data_out", int'(bus.data_out), 0);
    check("async_valid", int'(bus.data_out_valid), 0);
    check("async_phase", int'(bus.block_phase), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3 * R; i++) drive(1'b1, 100);
    drain();
    check("post_reset_first", first_out, 559);
    check("post_reset_steady", last_out, 3200);

    // Random data and random valid gaps, checked entirely by the scoreboard.
    do_reset();
    for (int i = 0; i < 12 * R; i++)
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 2047)) - 1024);
    drain();
    check("random_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
